// File: rtl/control_sequencer_if.sv
// Control bus between the SAP sequencer and the datapath.
// Carries the instruction register contents and ALU flags into the sequencer,
// and the one-hot control strobes, halt status and debug T-state out of it.
//   master : sequencer side (drives strobes, reads ir_out/flags)
//   slave  : datapath side (drives ir_out/flags, reads strobes)
interface control_sequencer_if;
    logic [15:0] ir_out;
    logic        carry_flag;
    logic        zero_flag;

    logic        pc_out;
    logic        pc_inc;
    logic        pc_load;
    logic        mar_write;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        addr_out;
    logic        a_write;
    logic        a_out;
    logic        b_write;
    logic        alu_sub;
    logic        alu_out;
    logic        flags_write;
    logic        out_write;
    logic        halted;
    logic [2:0]  t_state;

    modport master (
        input  ir_out, carry_flag, zero_flag,
        output pc_out, pc_inc, pc_load, mar_write, mem_read, mem_write,
               ir_write, addr_out, a_write, a_out, b_write, alu_sub,
               alu_out, flags_write, out_write, halted, t_state
    );

    modport slave (
        output ir_out, carry_flag, zero_flag,
        input  pc_out, pc_inc, pc_load, mar_write, mem_read, mem_write,
               ir_write, addr_out, a_write, a_out, b_write, alu_sub,
               alu_out, flags_write, out_write, halted, t_state
    );
endinterface

// File: rtl/control_sequencer.sv
// Instruction-cycle sequencer of the 16-bit SAP core.
// A registered T-state walks fetch (T1-T2) and execute (T3-T5); the opcode in
// ir_out[15:12] selects the execute micro-steps. Strobes are decoded
// combinationally from the registered state, opcode and flags.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active low
//   run  : permits a new fetch at an instruction boundary
//   bus  : control bus (master side) - ir_out/flags in, strobes/halted/t_state out
module control_sequencer #(
    parameter int unsigned OPC_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    control_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        HALT = 3'd7
    } state_t;

    localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'h1);
    localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h2);
    localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h3);
    localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4'h4);
    localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4'h5);
    localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h6);
    localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(4'h7);
    localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h8);
    localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'hE);
    localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

    state_t           state;
    state_t           state_next;
    logic             instr_end;
    logic [OPC_W-1:0] opcode;

    assign opcode      = bus.ir_out[15 -: OPC_W];
    assign bus.t_state = state;
    assign bus.halted  = (state == HALT);

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and control strobes.
    always_comb begin
        state_next      = state;
        instr_end       = 1'b0;
        bus.pc_out      = 1'b0;
        bus.pc_inc      = 1'b0;
        bus.pc_load     = 1'b0;
        bus.mar_write   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.addr_out    = 1'b0;
        bus.a_write     = 1'b0;
        bus.a_out       = 1'b0;
        bus.b_write     = 1'b0;
        bus.alu_sub     = 1'b0;
        bus.alu_out     = 1'b0;
        bus.flags_write = 1'b0;
        bus.out_write   = 1'b0;

        unique case (state)
            IDLE: begin
                if (run) state_next = T1;
            end
            T1: begin
                bus.pc_out    = 1'b1;
                bus.mar_write = 1'b1;
                state_next    = T2;
            end
            T2: begin
                bus.mem_read = 1'b1;
                bus.ir_write = 1'b1;
                bus.pc_inc   = 1'b1;
                state_next   = T3;
            end
            T3: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        bus.addr_out  = 1'b1;
                        bus.mar_write = 1'b1;
                        state_next    = T4;
                    end
                    OP_LDI: begin
                        bus.addr_out = 1'b1;
                        bus.a_write  = 1'b1;
                        instr_end    = 1'b1;
                    end
                    OP_JMP: begin
                        bus.addr_out = 1'b1;
                        bus.pc_load  = 1'b1;
                        instr_end    = 1'b1;
                    end
                    // Conditional jumps: flags are only looked at here.
                    OP_JC: begin
                        bus.addr_out = bus.carry_flag;
                        bus.pc_load  = bus.carry_flag;
                        instr_end    = 1'b1;
                    end
                    OP_JZ: begin
                        bus.addr_out = bus.zero_flag;
                        bus.pc_load  = bus.zero_flag;
                        instr_end    = 1'b1;
                    end
                    OP_OUT: begin
                        bus.a_out     = 1'b1;
                        bus.out_write = 1'b1;
                        instr_end     = 1'b1;
                    end
                    OP_HLT: begin
                        state_next = HALT;
                    end
                    default: begin
                        instr_end = 1'b1;
                    end
                endcase
            end
            T4: begin
                case (opcode)
                    OP_LDA: begin
                        bus.mem_read = 1'b1;
                        bus.a_write  = 1'b1;
                        instr_end    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus.mem_read = 1'b1;
                        bus.b_write  = 1'b1;
                        state_next   = T5;
                    end
                    OP_STA: begin
                        bus.a_out     = 1'b1;
                        bus.mem_write = 1'b1;
                        instr_end     = 1'b1;
                    end
                    default: begin
                        instr_end = 1'b1;
                    end
                endcase
            end
            T5: begin
                bus.alu_out     = 1'b1;
                bus.a_write     = 1'b1;
                bus.flags_write = 1'b1;
                bus.alu_sub     = (opcode == OP_SUB);
                instr_end       = 1'b1;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // run only gates entry into the next fetch.
        if (instr_end) state_next = run ? T1 : IDLE;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed boundary cases plus a
// randomized instruction stream checked against a micro-program table model.
module tb_control_sequencer;

    // Strobe vector bit weights (order matches obs below).
    localparam logic [14:0] PC_OUT  = 15'h4000;
    localparam logic [14:0] PC_INC  = 15'h2000;
    localparam logic [14:0] PC_LOAD = 15'h1000;
    localparam logic [14:0] MAR_W   = 15'h0800;
    localparam logic [14:0] MEM_RD  = 15'h0400;
    localparam logic [14:0] MEM_WR  = 15'h0200;
    localparam logic [14:0] IR_W    = 15'h0100;
    localparam logic [14:0] ADDR    = 15'h0080;
    localparam logic [14:0] A_W     = 15'h0040;
    localparam logic [14:0] A_O     = 15'h0020;
    localparam logic [14:0] B_W     = 15'h0010;
    localparam logic [14:0] SUBS    = 15'h0008;
    localparam logic [14:0] ALU_O   = 15'h0004;
    localparam logic [14:0] FLG     = 15'h0002;
    localparam logic [14:0] OUT_W   = 15'h0001;
    localparam logic [14:0] BUS_DRV = PC_OUT | MEM_RD | ADDR | A_O | ALU_O;

    logic clk;
    logic rst;
    logic run;

    control_sequencer_if bus ();

    control_sequencer #(.OPC_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .run (run),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [14:0] obs;
    assign obs = {bus.pc_out, bus.pc_inc, bus.pc_load, bus.mar_write, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.addr_out, bus.a_write, bus.a_out,
                  bus.b_write, bus.alu_sub, bus.alu_out, bus.flags_write, bus.out_write};

    int errors = 0;
    int checks = 0;

    logic [14:0] exp_seq [5];
    int          exp_len;
    bit          exp_halt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Micro-program of one instruction: fetch followed by the execute steps.
    task automatic build_expected(input logic [3:0] op, input logic c, input logic z);
        exp_halt   = 1'b0;
        exp_seq[0] = PC_OUT | MAR_W;
        exp_seq[1] = MEM_RD | IR_W | PC_INC;
        exp_len    = 3;
        exp_seq[2] = '0;
        case (op)
            4'h1: begin
                exp_seq[2] = ADDR | MAR_W;
                exp_seq[3] = MEM_RD | A_W;
                exp_len    = 4;
            end
            4'h2, 4'h3: begin
                exp_seq[2] = ADDR | MAR_W;
                exp_seq[3] = MEM_RD | B_W;
                exp_seq[4] = ALU_O | A_W | FLG | ((op == 4'h3) ? SUBS : 15'h0);
                exp_len    = 5;
            end
            4'h4: begin
                exp_seq[2] = ADDR | MAR_W;
                exp_seq[3] = A_O | MEM_WR;
                exp_len    = 4;
            end
            4'h5: exp_seq[2] = ADDR | A_W;
            4'h6: exp_seq[2] = ADDR | PC_LOAD;
            4'h7: exp_seq[2] = c ? (ADDR | PC_LOAD) : 15'h0;
            4'h8: exp_seq[2] = z ? (ADDR | PC_LOAD) : 15'h0;
            4'hE: exp_seq[2] = A_O | OUT_W;
            4'hF: exp_halt   = 1'b1;
            default: exp_seq[2] = '0;
        endcase
    endtask

    function automatic logic [31:0] drivers(input logic [14:0] v);
        return 32'($countones(v & BUS_DRV));
    endfunction

    // Entered at a negedge with the DUT in T1; leaves at the negedge after the last step.
    task automatic exec_instr(input logic [15:0] ir, input logic c, input logic z,
                              input logic run_after);
        bus.ir_out     = ir;
        bus.carry_flag = c;
        bus.zero_flag  = z;
        build_expected(ir[15:12], c, z);
        for (int i = 0; i < exp_len; i++) begin
            check("t_state", 32'(bus.t_state), 32'(i + 1));
            check("strobes", 32'(obs), 32'(exp_seq[i]));
            check("halted", 32'(bus.halted), 32'd0);
            check("one_driver", (drivers(obs) <= 1) ? 32'd1 : 32'd0, 32'd1);
            run = (i == exp_len - 1) ? run_after : 1'($urandom % 2);
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(bus.t_state), 32'd0);
        check({tag, "_strobes"}, 32'(obs), 32'd0);
        check({tag, "_halted"}, 32'(bus.halted), 32'd0);
    endtask

    initial begin
        rst            = 1'b0;
        run            = 1'b0;
        bus.ir_out     = '0;
        bus.carry_flag = 1'b0;
        bus.zero_flag  = 1'b0;

        // Reset held for 3 clocks, then released with run=0.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        @(negedge clk);
        check_idle("idle_after_release");
        @(negedge clk);
        check_idle("idle_hold");

        // Directed: LDA, SUB, JC not taken / taken.
        run = 1'b1;
        @(negedge clk);
        exec_instr(16'h100A, 1'b0, 1'b0, 1'b1);
        exec_instr(16'h3005, 1'b0, 1'b0, 1'b1);
        exec_instr(16'h7020, 1'b0, 1'b1, 1'b1);
        exec_instr(16'h7020, 1'b1, 1'b0, 1'b1);
        exec_instr(16'h8020, 1'b1, 1'b1, 1'b1);

        // Randomized instruction stream (HLT excluded), occasional pause.
        for (int n = 0; n < 80; n++) begin
            logic [15:0] ir;
            logic        ra;
            ir = 16'($urandom);
            if (ir[15:12] == 4'hF) ir[15:12] = 4'($urandom_range(0, 14));
            ra = ($urandom % 4) != 0;
            exec_instr(ir, 1'($urandom % 2), 1'($urandom % 2), ra);
            if (!ra) begin
                check_idle("pause");
                @(negedge clk);
                check_idle("pause_hold");
                run = 1'b1;
                @(negedge clk);
            end
        end

        // Reset in T4 of ADD aborts it within the same cycle.
        bus.ir_out = 16'h2040;
        check("add_t1", 32'(bus.t_state), 32'd1);
        repeat (3) @(negedge clk);
        check("add_t4_state", 32'(bus.t_state), 32'd4);
        check("add_t4_strobes", 32'(obs), 32'(MEM_RD | B_W));
        #2 rst = 1'b0;
        #1;
        check_idle("abort");
        @(negedge clk);
        run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort_release");

        // Pause at instruction end: NOP with run dropped.
        run = 1'b1;
        @(negedge clk);
        exec_instr(16'h0000, 1'b0, 1'b0, 1'b0);
        check_idle("nop_pause");
        @(negedge clk);
        check_idle("nop_pause_hold");

        // HLT: halted held regardless of run until reset.
        run = 1'b1;
        @(negedge clk);
        exec_instr(16'hF000, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            check("halt_state", 32'(bus.t_state), 32'd7);
            check("halt_flag", 32'(bus.halted), 32'd1);
            check("halt_strobes", 32'(obs), 32'd0);
            run = 1'($urandom % 2);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check_idle("halt_reset");
        @(negedge clk);
        run = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_idle("halt_reset_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
